// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//
// Buffers ALU commands in a small FIFO and runs them one at a time against an
// external multi-cycle ALU. Each accepted command returns exactly one response,
// in acceptance order. A no-op or illegal opcode is answered directly without
// starting the ALU. An ALU that never signals completion is aborted after
// TIMEOUT cycles with an error response.
//
// Parameters
//   DEPTH      command FIFO entries (power of two, 2..16)
//   TIMEOUT    max cycles alu_start is held without alu_done before abort
//
// Ports
//   clk, reset                   clock, synchronous active-high reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_op, cmd_a, cmd_b         command payload (opcode, operands)
//   alu_A, alu_B, alu_op         operands/opcode presented to the ALU
//   alu_start                    held high while an ALU operation is pending
//   alu_done, alu_result         ALU completion and result
//   rsp_valid/rsp_ready          response handshake
//   rsp_result, rsp_op, rsp_err  response payload
//   busy                         FSM not idle or FIFO non-empty
module alu_cmd_sequencer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    // Command side
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    // ALU side
    output logic [7:0]  alu_A,
    output logic [7:0]  alu_B,
    output logic [2:0]  alu_op,
    output logic        alu_start,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    // Response side
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [2:0]  rsp_op,
    output logic        rsp_err,
    // Status
    output logic        busy
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned ToW  = $clog2(TIMEOUT + 1);

    localparam logic [2:0] OpNop  = 3'b000;
    localparam logic [2:0] OpAdd  = 3'b001;
    localparam logic [2:0] OpAnd  = 3'b010;
    localparam logic [2:0] OpXor  = 3'b011;
    localparam logic [2:0] OpMult = 3'b100;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StResp
    } state_e;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    cmd_t            mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    cmd_t            head;

    assign full      = (count_q == CntW'(DEPTH));
    assign empty     = (count_q == '0);
    // Ready depends only on occupancy: a pop in the same cycle does not free
    // a slot for a push, so there is no combinational path from the FSM here.
    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem_q[rd_ptr_q];

    // Storage is not reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{op: cmd_op, a: cmd_a, b: cmd_b};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow wraps.
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    state_e         state_q, state_d;
    logic [7:0]     alu_a_q, alu_a_d;
    logic [7:0]     alu_b_q, alu_b_d;
    logic [2:0]     alu_op_q, alu_op_d;
    logic [ToW-1:0] to_cnt_q, to_cnt_d;
    logic [15:0]    rsp_result_q, rsp_result_d;
    logic [2:0]     rsp_op_q, rsp_op_d;
    logic           rsp_err_q, rsp_err_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            to_cnt_q     <= '0;
            rsp_result_q <= '0;
            rsp_op_q     <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            to_cnt_q     <= to_cnt_d;
            rsp_result_q <= rsp_result_d;
            rsp_op_q     <= rsp_op_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        to_cnt_d     = to_cnt_q;
        rsp_result_d = rsp_result_q;
        rsp_op_d     = rsp_op_q;
        rsp_err_d    = rsp_err_q;
        pop          = 1'b0;

        case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop      = 1'b1;
                    rsp_op_d = head.op;
                    case (head.op)
                        OpNop: begin
                            rsp_result_d = '0;
                            rsp_err_d    = 1'b0;
                            state_d      = StResp;
                        end
                        OpAdd, OpAnd, OpXor, OpMult: begin
                            alu_a_d  = head.a;
                            alu_b_d  = head.b;
                            alu_op_d = head.op;
                            // First ISSUE cycle counts as 1.
                            to_cnt_d = ToW'(1);
                            state_d  = StIssue;
                        end
                        default: begin
                            rsp_result_d = '0;
                            rsp_err_d    = 1'b1;
                            state_d      = StResp;
                        end
                    endcase
                end
            end

            StIssue: begin
                // Completion wins over timeout when both land in the same cycle.
                if (alu_done) begin
                    rsp_result_d = alu_result;
                    rsp_err_d    = 1'b0;
                    to_cnt_d     = '0;
                    state_d      = StResp;
                end else if (to_cnt_q == ToW'(TIMEOUT)) begin
                    rsp_result_d = '0;
                    rsp_err_d    = 1'b1;
                    to_cnt_d     = '0;
                    state_d      = StResp;
                end else begin
                    to_cnt_d = to_cnt_q + ToW'(1);
                end
            end

            StResp: begin
                // Payload registers are untouched here, so they hold while stalled.
                // Passing through RESP also guarantees a low cycle on alu_start.
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign alu_A      = alu_a_q;
    assign alu_B      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign alu_start  = (state_q == StIssue);
    assign rsp_valid  = (state_q == StResp);
    assign rsp_result = rsp_result_q;
    assign rsp_op     = rsp_op_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = (state_q != StIdle) || !empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: reset state, per-opcode latency and
// results, illegal opcodes, FIFO back-pressure and ordering, ALU timeout, and
// reset while an ALU operation is in flight. Inputs change and outputs are
// sampled on the falling edge.
module tb_alu_cmd_sequencer;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic [7:0]  alu_A;
    logic [7:0]  alu_B;
    logic [2:0]  alu_op;
    logic        alu_start;
    logic        alu_done;
    logic [15:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic [2:0]  rsp_op;
    logic        rsp_err;
    logic        busy;

    alu_cmd_sequencer #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_A      (alu_A),
        .alu_B      (alu_B),
        .alu_op     (alu_op),
        .alu_start  (alu_start),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_op     (rsp_op),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU model: done is high in the (lat+1)-th cycle of alu_start, so it is
    // seen lat cycles after start is first seen. lat == 0 never completes.
    int   alu_lat   = 1;
    int   start_cnt = 0;
    logic model_done = 1'b0;
    logic late_done  = 1'b0;

    always @(negedge clk) begin
        if (alu_start) start_cnt = start_cnt + 1;
        else           start_cnt = 0;
        model_done = (alu_lat > 0) && alu_start && (start_cnt == alu_lat + 1);
    end

    assign alu_done = model_done | late_done;

    always_comb begin
        case (alu_op)
            3'b001:  alu_result = {8'h00, alu_A} + {8'h00, alu_B};
            3'b010:  alu_result = {8'h00, alu_A & alu_B};
            3'b011:  alu_result = {8'h00, alu_A ^ alu_B};
            3'b100:  alu_result = 16'(alu_A) * 16'(alu_B);
            default: alu_result = 16'hDEAD;
        endcase
    end

    int n_chk  = 0;
    int n_pass = 0;
    int last_n = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called on a falling edge; returns on the falling edge after acceptance,
    // with last_n holding the index of the accepting rising edge.
    task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int t;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        t = 0;
        while (!cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) chk("push_accept", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        last_n    = cyc;
        cmd_valid = 1'b0;
    endtask

    // Scan falling edges until rsp_valid; deltas are edges elapsed since push.
    task automatic await_rsp(input int n, output int st_d, output int st_cyc,
                             output int rsp_d, output logic [15:0] res,
                             output logic [2:0] op, output logic err);
        st_d   = -1;
        st_cyc = 0;
        rsp_d  = -1;
        res    = 'x;
        op     = 'x;
        err    = 1'bx;
        for (int t = 0; t < 100; t++) begin
            if (alu_start) begin
                if (st_d < 0) st_d = cyc - n;
                st_cyc++;
            end
            if (rsp_valid) begin
                rsp_d = cyc - n;
                res   = rsp_result;
                op    = rsp_op;
                err   = rsp_err;
                break;
            end
            @(negedge clk);
        end
    endtask

    logic [2:0]  q_op  [6] = '{3'd1, 3'd0, 3'd3, 3'd7, 3'd2, 3'd4};
    logic [15:0] q_res [6] = '{16'h0016, 16'h0000, 16'h0006, 16'h0000, 16'h0008, 16'h0078};
    logic        q_err [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          st_d, st_cyc, rsp_d, n1, idx;
        logic [15:0] res;
        logic [2:0]  op;
        logic        err;
        logic        acc;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("rst_cmd_ready",  32'(cmd_ready),  32'd1);
        chk("rst_alu_start",  32'(alu_start),  32'd0);
        chk("rst_alu_A",      32'(alu_A),      32'd0);
        chk("rst_alu_B",      32'(alu_B),      32'd0);
        chk("rst_alu_op",     32'(alu_op),     32'd0);
        chk("rst_rsp_valid",  32'(rsp_valid),  32'd0);
        chk("rst_rsp_result", 32'(rsp_result), 32'd0);
        chk("rst_rsp_op",     32'(rsp_op),     32'd0);
        chk("rst_rsp_err",    32'(rsp_err),    32'd0);
        chk("rst_busy",       32'(busy),       32'd0);

        // add FF+01, ALU done one cycle after start
        alu_lat = 1;
        push(3'b001, 8'hFF, 8'h01);
        n1 = last_n;
        @(negedge clk);
        chk("add_start",  32'(alu_start), 32'd1);
        chk("add_alu_A",  32'(alu_A),     32'h0FF);
        chk("add_alu_B",  32'(alu_B),     32'h001);
        chk("add_alu_op", 32'(alu_op),    32'd1);
        chk("add_busy",   32'(busy),      32'd1);
        await_rsp(n1, st_d, st_cyc, rsp_d, res, op, err);
        chk("add_rsp_lat", 32'(rsp_d), 32'd3);
        chk("add_result",  32'(res),   32'h0100);
        chk("add_err",     32'(err),   32'd0);
        chk("add_op",      32'(op),    32'd1);
        @(negedge clk);
        chk("add_rsp_drop", 32'(rsp_valid), 32'd0);

        // mult FF*FF, ALU done three cycles after start
        alu_lat = 3;
        push(3'b100, 8'hFF, 8'hFF);
        await_rsp(last_n, st_d, st_cyc, rsp_d, res, op, err);
        chk("mul_start_lat", 32'(st_d),  32'd1);
        chk("mul_rsp_lat",   32'(rsp_d), 32'd5);
        chk("mul_result",    32'(res),   32'hFE01);
        chk("mul_op",        32'(op),    32'd4);
        chk("mul_err",       32'(err),   32'd0);
        @(negedge clk);

        // no-op answered directly
        push(3'b000, 8'h12, 8'h34);
        await_rsp(last_n, st_d, st_cyc, rsp_d, res, op, err);
        chk("nop_start_cyc", 32'(st_cyc), 32'd0);
        chk("nop_rsp_lat",   32'(rsp_d),  32'd1);
        chk("nop_result",    32'(res),    32'd0);
        chk("nop_err",       32'(err),    32'd0);
        @(negedge clk);

        // illegal 110 followed by xor A5^0F
        alu_lat = 1;
        push(3'b110, 8'h55, 8'h66);
        n1 = last_n;
        push(3'b011, 8'hA5, 8'h0F);
        await_rsp(n1, st_d, st_cyc, rsp_d, res, op, err);
        chk("ill_start_cyc", 32'(st_cyc), 32'd0);
        chk("ill_rsp_lat",   32'(rsp_d),  32'd1);
        chk("ill_err",       32'(err),    32'd1);
        chk("ill_result",    32'(res),    32'd0);
        chk("ill_op",        32'(op),     32'd6);
        @(negedge clk);
        await_rsp(last_n, st_d, st_cyc, rsp_d, res, op, err);
        chk("xor_result", 32'(res), 32'h00AA);
        chk("xor_err",    32'(err), 32'd0);
        chk("xor_op",     32'(op),  32'd3);
        @(negedge clk);

        // Back-pressure: one in RESP plus DEPTH queued, then drain in order
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(q_op[i], 8'h0C, 8'h0A);
        chk("full_cmd_ready", 32'(cmd_ready),  32'd0);
        chk("full_busy",      32'(busy),       32'd1);
        chk("full_rsp_valid", 32'(rsp_valid),  32'd1);
        chk("full_rsp_hold0", 32'(rsp_result), 32'h0016);
        cmd_valid = 1'b1;
        cmd_op    = q_op[5];
        cmd_a     = 8'h0C;
        cmd_b     = 8'h0A;
        repeat (3) @(negedge clk);
        chk("full_still_blocked", 32'(cmd_ready),  32'd0);
        chk("full_rsp_hold1",     32'(rsp_result), 32'h0016);
        chk("full_rsp_op_hold",   32'(rsp_op),     32'd1);
        rsp_ready = 1'b1;
        acc = 1'b0;
        idx = 0;
        for (int t = 0; t < 200 && idx < 6; t++) begin
            if (acc) cmd_valid = 1'b0;
            acc = cmd_valid && cmd_ready;
            if (rsp_valid) begin
                chk($sformatf("order_%0d", idx), 32'({rsp_err, rsp_op, rsp_result}),
                    32'({q_err[idx], q_op[idx], q_res[idx]}));
                idx++;
            end
            @(negedge clk);
        end
        chk("order_count", 32'(idx), 32'd6);
        cmd_valid = 1'b0;

        // ALU never completes: abort after TIMEOUT cycles of alu_start
        alu_lat = 0;
        push(3'b001, 8'h01, 8'h02);
        await_rsp(last_n, st_d, st_cyc, rsp_d, res, op, err);
        chk("to_start_lat", 32'(st_d),   32'd1);
        chk("to_start_cyc", 32'(st_cyc), 32'd15);
        chk("to_rsp_lat",   32'(rsp_d),  32'd16);
        chk("to_err",       32'(err),    32'd1);
        chk("to_result",    32'(res),    32'd0);
        @(negedge clk);

        // Reset in the middle of a multiply
        alu_lat = 3;
        push(3'b100, 8'h03, 8'h05);
        repeat (2) @(negedge clk);
        chk("mr_in_issue", 32'(alu_start), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mr_alu_start", 32'(alu_start), 32'd0);
        chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mr_busy",      32'(busy),      32'd0);
        chk("mr_cmd_ready", 32'(cmd_ready), 32'd1);
        late_done = 1'b1;
        repeat (2) @(negedge clk);
        late_done = 1'b0;
        @(negedge clk);
        chk("late_rsp_valid",  32'(rsp_valid),  32'd0);
        chk("late_busy",       32'(busy),       32'd0);
        chk("late_alu_start",  32'(alu_start),  32'd0);
        chk("late_rsp_result", 32'(rsp_result), 32'd0);

        // Recovery: a fresh no-op is answered normally
        push(3'b000, 8'h00, 8'h00);
        await_rsp(last_n, st_d, st_cyc, rsp_d, res, op, err);
        chk("rec_rsp_lat", 32'(rsp_d), 32'd1);
        chk("rec_op",      32'(op),    32'd0);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
